node3_switch: RTL
=================

# node3_switch

Switch-allocation and crossbar stage for the 3-port router node. Sits directly downstream of the three per-port input FIFOs: reads each FIFO head, computes the output port from the head flit's destination, performs per-output round-robin arbitration with wormhole locking, and drives one registered output stage per port toward the port converters. One flit per output per cycle, one cycle latency.

## Interface
Parameters:
- NODE_X, 0, X coordinate of this node (4 bits significant)
- NODE_Y, 0, Y coordinate of this node (4 bits significant)

Ports (index 0 = local, 1 = node_0 side, 2 = node_1 side):
- clk  in  1  single clock; one clock domain
- rst  in  1  asynchronous, active-low reset
- in_valid[0:2]  in  1 each  FIFO head holds a valid flit
- in_data[0:2]  in  16 each  FIFO head flit
- in_pop[0:2]  out  1 each  pop request to FIFO; head consumed this cycle
- out_full[0:2]  in  1 each  downstream buffer full; hold output
- out_valid[0:2]  out  1 each  output register holds a flit
- out_data[0:2]  out  16 each  output flit
- proto_err  out  1  one-cycle pulse: orphan body/tail flit dropped

## Operation
- Flit format: [15:14] type (00 body, 01 head, 10 tail, 11 single = head+tail); head/single: [13:10] dest_x, [9:6] dest_y, [5:0] payload.
- Routing (head/single only): dest == (NODE_X,NODE_Y) -> port 0; else dest_x != NODE_X -> port 1; else port 2. Input may route to its own output index.
- Per-output FSM: IDLE, LOCKED(owner).
  - IDLE: requesters = inputs with valid head/single routed to this output and not owning another output. Round-robin grant, search starts at rr_ptr. Head granted -> LOCKED(owner); single granted -> stay IDLE. rr_ptr <= winner+1 mod 3 on every grant.
  - LOCKED: only owner's flits forwarded, any type except head/single (a head from owner while locked is held, not forwarded). Tail transfer -> IDLE.
- Transfer condition for output j in a cycle: granted/owner flit valid AND (out_valid[j]==0 OR out_full[j]==0). On transfer: in_pop[owner]=1, out_data[j] <= flit, out_valid[j] <= 1.
- Output drain: out_valid[j] & !out_full[j] means downstream takes the flit this cycle; register clears unless refilled same cycle.
- Body/tail at an input not owning any output: popped and discarded, proto_err pulses next cycle. Never forwarded.
- in_pop is combinational from state and inputs; at most one output consumes a given input per cycle.

## Timing
- Reset (rst low, async): out_valid=0, out_data=0, all FSMs IDLE, rr_ptr=0, proto_err=0; in_pop forced 0 while rst low.
- Latency: flit at FIFO head in cycle N, popped in N, on out_data in N+1.
- Throughput: 1 flit/cycle/output with out_full low; three disjoint flows proceed concurrently.
- out_full high with out_valid high: register and out_data hold, no pop for that output; lock retained.
- Simultaneous drain and refill: allowed, no bubble.
- Reset mid-packet: locks dropped; partial packet downstream is not completed.

## Structure
- Package noc_pkg: NUM_PORTS=3, port index constants (PORT_LOCAL, PORT_N0, PORT_N1), flit_type_e enum, field bit-position constants, flit_t 16-bit typedef.
- Sub-module rr_arbiter: 3-request round-robin, inputs req[2:0], ptr; outputs grant one-hot, winner index. Instantiated once per output.

## Test plan
- NODE=(1,1); input 1 single 16'hC440 (dest 1,1) -> out_valid[0] next cycle, out_data[0]=16'hC440, in_pop[1] one cycle.
- Inputs 0,1,2 each head to dest (3,1) same cycle, each 3-flit packet -> port 1 serves input 0 packet fully, then 1, then 2; no interleaving; rr_ptr wraps to 0.
- Packet head/body/tail input 2 -> port 2 with out_full[2] high 4 cycles mid-packet -> out_data holds, no pops, packet completes intact after release.
- Concurrent: input 0 -> port 1, input 1 -> port 2, input 2 -> port 0 -> all three outputs valid every cycle, 1-cycle latency.
- Body flit 16'h0123 at idle input 0 -> popped, proto_err pulses once, no out_valid.
- rst low mid-packet -> all out_valid 0 immediately; after release new head arbitrated from rr_ptr=0.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared types and constants for the 3-port router node.
package noc_pkg;

    localparam int unsigned NUM_PORTS = 3;
    localparam int unsigned FLIT_W    = 16;

    localparam logic [1:0] PORT_LOCAL = 2'd0;
    localparam logic [1:0] PORT_N0    = 2'd1;
    localparam logic [1:0] PORT_N1    = 2'd2;

    localparam int unsigned TYPE_MSB = 15;
    localparam int unsigned TYPE_LSB = 14;
    localparam int unsigned DX_MSB   = 13;
    localparam int unsigned DX_LSB   = 10;
    localparam int unsigned DY_MSB   = 9;
    localparam int unsigned DY_LSB   = 6;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef enum logic [1:0] {
        FLIT_BODY   = 2'b00,
        FLIT_HEAD   = 2'b01,
        FLIT_TAIL   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_type_e;

    // Extract the flit type field.
    function automatic flit_type_e flit_type(input flit_t f);
        return flit_type_e'(f[TYPE_MSB:TYPE_LSB]);
    endfunction

    // Output port for a head/single flit: local, else X first, else Y side.
    function automatic logic [1:0] route_port(input flit_t f, input logic [3:0] nx, input logic [3:0] ny);
        logic [3:0] dx;
        logic [3:0] dy;
        dx = f[DX_MSB:DX_LSB];
        dy = f[DY_MSB:DY_LSB];
        if (dx == nx && dy == ny) return PORT_LOCAL;
        if (dx != nx)             return PORT_N0;
        return PORT_N1;
    endfunction

endpackage

// File: rtl/node3_switch_rr_arbiter.sv
// Three-requester round-robin arbiter; search begins at i_ptr.
module rr_arbiter
    import noc_pkg::*;
(
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [1:0]           i_ptr,
    output logic [NUM_PORTS-1:0] o_grant_c,
    output logic [1:0]           o_winner_c
);

    logic [2:0] w_sum;
    logic [1:0] w_idx;

    // Walk candidates from farthest to nearest so the nearest requester wins.
    always_comb begin
        o_grant_c  = '0;
        o_winner_c = '0;
        w_sum      = '0;
        w_idx      = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            w_sum = 3'(i_ptr) + 3'(k);
            w_idx = (w_sum >= 3'(NUM_PORTS)) ? 2'(w_sum - 3'(NUM_PORTS)) : 2'(w_sum);
            if (i_req[w_idx]) begin
                o_grant_c  = 3'(1) << w_idx;
                o_winner_c = w_idx;
            end
        end
    end

endmodule

// File: rtl/node3_switch.sv
// Switch allocation + crossbar: per-output round-robin with wormhole locking,
// one registered output stage per port.
module node3_switch
    import noc_pkg::*;
#(
    parameter int unsigned NODE_X = 0,
    parameter int unsigned NODE_Y = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          i_valid,
    input  logic [NUM_PORTS*FLIT_W-1:0]   i_data,
    output logic [NUM_PORTS-1:0]          o_pop_c,
    input  logic [NUM_PORTS-1:0]          i_full,
    output logic [NUM_PORTS-1:0]          o_valid,
    output logic [NUM_PORTS*FLIT_W-1:0]   o_data,
    output logic                          o_proto_err
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } out_state_e;

    out_state_e                  r_state     [NUM_PORTS];
    out_state_e                  w_state_nxt [NUM_PORTS];
    logic [1:0]                  r_owner     [NUM_PORTS];
    logic [1:0]                  w_owner_nxt [NUM_PORTS];
    logic [1:0]                  r_rr_ptr    [NUM_PORTS];
    logic [1:0]                  w_rr_ptr_nxt[NUM_PORTS];
    logic [NUM_PORTS-1:0]        r_valid, w_valid_nxt;
    logic [NUM_PORTS*FLIT_W-1:0] r_data, w_data_nxt;
    logic                        r_proto_err, w_proto_err_nxt;
    logic [NUM_PORTS-1:0]        w_pop;

    flit_t                       w_flit  [NUM_PORTS];
    flit_type_e                  w_type  [NUM_PORTS];
    logic [1:0]                  w_route [NUM_PORTS];
    logic [NUM_PORTS-1:0]        w_owns;
    logic [NUM_PORTS-1:0]        w_req   [NUM_PORTS];
    logic [NUM_PORTS-1:0]        w_grant [NUM_PORTS];
    logic [1:0]                  w_winner[NUM_PORTS];

    // Decode each FIFO head and note which inputs currently own an output.
    always_comb begin
        w_owns = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_flit[i]  = i_data[FLIT_W*i +: FLIT_W];
            w_type[i]  = flit_type(w_flit[i]);
            w_route[i] = route_port(w_flit[i], 4'(NODE_X), 4'(NODE_Y));
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (r_state[j] == ST_LOCKED && r_owner[j] == 2'(i)) w_owns[i] = 1'b1;
            end
        end
    end

    // New-packet requests: unlocked-input heads/singles routed to each output.
    always_comb begin
        for (int j = 0; j < NUM_PORTS; j++) begin
            w_req[j] = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                w_req[j][i] = i_valid[i] && !w_owns[i] && w_route[i] == 2'(j) &&
                              (w_type[i] == FLIT_HEAD || w_type[i] == FLIT_SINGLE);
            end
        end
    end

    for (genvar j = 0; j < NUM_PORTS; j++) begin : g_arb
        rr_arbiter u_arb (
            .i_req      (w_req[j]),
            .i_ptr      (r_rr_ptr[j]),
            .o_grant_c  (w_grant[j]),
            .o_winner_c (w_winner[j])
        );
    end

    // Per-output FSM next state, crossbar transfers, pops and orphan drops.
    always_comb begin
        logic       can_acc;
        logic [1:0] src;
        can_acc          = 1'b0;
        src              = '0;
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_rr_ptr_nxt     = r_rr_ptr;
        w_valid_nxt      = r_valid & i_full;
        w_data_nxt       = r_data;
        w_pop            = '0;
        w_proto_err_nxt  = 1'b0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            can_acc = !r_valid[j] || !i_full[j];
            case (r_state[j])
                ST_IDLE: begin
                    if ((|w_grant[j]) && can_acc) begin
                        src                         = w_winner[j];
                        w_pop[src]                  = 1'b1;
                        w_data_nxt[FLIT_W*j +: FLIT_W] = w_flit[src];
                        w_valid_nxt[j]              = 1'b1;
                        w_rr_ptr_nxt[j]             = (src == 2'd2) ? 2'd0 : src + 2'd1;
                        if (w_type[src] == FLIT_HEAD) begin
                            w_state_nxt[j] = ST_LOCKED;
                            w_owner_nxt[j] = src;
                        end
                    end
                end
                ST_LOCKED: begin
                    src = r_owner[j];
                    if (i_valid[src] && can_acc &&
                        (w_type[src] == FLIT_BODY || w_type[src] == FLIT_TAIL)) begin
                        w_pop[src]                  = 1'b1;
                        w_data_nxt[FLIT_W*j +: FLIT_W] = w_flit[src];
                        w_valid_nxt[j]              = 1'b1;
                        if (w_type[src] == FLIT_TAIL) w_state_nxt[j] = ST_IDLE;
                    end
                end
                default: w_state_nxt[j] = ST_IDLE;
            endcase
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (i_valid[i] && !w_owns[i] && (w_type[i] == FLIT_BODY || w_type[i] == FLIT_TAIL)) begin
                w_pop[i]        = 1'b1;
                w_proto_err_nxt = 1'b1;
            end
        end
    end

    // State, pointers and output stage registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                r_state[j]  <= ST_IDLE;
                r_owner[j]  <= '0;
                r_rr_ptr[j] <= '0;
            end
            r_valid     <= '0;
            r_data      <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_valid     <= w_valid_nxt;
            r_data      <= w_data_nxt;
            r_proto_err <= w_proto_err_nxt;
        end
    end

    assign o_pop_c     = w_pop & {NUM_PORTS{rst}};
    assign o_valid     = r_valid;
    assign o_data      = r_data;
    assign o_proto_err = r_proto_err;

endmodule
